// File: rtl/dual_port_bram_rc_if.sv
// Request/response bundle for dual_port_bram_rc: write port, read port and clear handshake.
interface dual_port_bram_rc_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    clear_req;
    logic                    ready;
    logic                    wr_en;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic [ADDR_WIDTH-1:0]   write_addr;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   read_addr;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    rd_valid;

    modport master (
        output clear_req, wr_en, wr_be, write_addr, write_data, rd_en, read_addr,
        input  ready, read_data, rd_valid
    );

    modport slave (
        input  clear_req, wr_en, wr_be, write_addr, write_data, rd_en, read_addr,
        output ready, read_data, rd_valid
    );
endinterface

// File: rtl/dual_port_bram_rc.sv
// Simple dual-port BRAM with a hardware clear sequence (reset or clear_req), byte enables,
// optional same-address bypass and a 1- or 2-cycle read pipeline.
module dual_port_bram_rc #(
    parameter int unsigned           ADDR_WIDTH   = 8,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    parameter int unsigned           READ_LATENCY = 1,
    parameter bit                    BYPASS       = 1'b0
) (
    input logic                clk,
    input logic                reset,
    dual_port_bram_rc_if.slave bus
);
    localparam int unsigned         MEM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned         NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] CNT_LAST  = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e              state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  active;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data1_q;
    logic                  rd_valid1_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StClear: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = StReady;
                end
            end
            StReady: ;
            default: state_d = StClear;
        endcase
        // A clear request restarts the sweep from address 0 in either state.
        if (bus.clear_req) begin
            state_d = StClear;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign active    = (state_q == StReady) && !reset;
    assign wr_ok     = active && bus.wr_en;
    assign rd_ok     = active && bus.rd_en;
    assign bus.ready = (state_q == StReady);

    // Storage has no reset so it maps onto block RAM; the sweep owns the port while clearing.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[cnt_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.wr_be[i]) begin
                    mem[bus.write_addr][8*i +: 8] <= bus.write_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[bus.read_addr];
        if (BYPASS && wr_ok && (bus.write_addr == bus.read_addr)) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.wr_be[i]) begin
                    rd_word[8*i +: 8] = bus.write_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data1_q  <= '0;
            rd_valid1_q <= 1'b0;
        end else begin
            rd_valid1_q <= rd_ok;
            if (rd_ok) begin
                rd_data1_q <= rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] rd_data2_q;
        logic                  rd_valid2_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data2_q  <= '0;
                rd_valid2_q <= 1'b0;
            end else begin
                rd_valid2_q <= rd_valid1_q;
                if (rd_valid1_q) begin
                    rd_data2_q <= rd_data1_q;
                end
            end
        end

        assign bus.read_data = rd_data2_q;
        assign bus.rd_valid  = rd_valid2_q;
    end else begin : g_lat1
        assign bus.read_data = rd_data1_q;
        assign bus.rd_valid  = rd_valid1_q;
    end
endmodule

// File: tb/tb_dual_port_bram_rc.sv
// Drives a latency-1/no-bypass and a latency-2/bypass instance with identical stimulus and
// compares both against an array model of the memory and clear timing.
module tb_dual_port_bram_rc;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] INIT  = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_req;
    logic          wr_en;
    logic [3:0]    wr_be;
    logic [AW-1:0] write_addr;
    logic [31:0]   write_data;
    logic          rd_en;
    logic [AW-1:0] read_addr;

    always #5 clk = ~clk;

    dual_port_bram_rc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    dual_port_bram_rc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.clear_req  = clear_req;
    assign bus0.wr_en      = wr_en;
    assign bus0.wr_be      = wr_be;
    assign bus0.write_addr = write_addr;
    assign bus0.write_data = write_data;
    assign bus0.rd_en      = rd_en;
    assign bus0.read_addr  = read_addr;
    assign bus1.clear_req  = clear_req;
    assign bus1.wr_en      = wr_en;
    assign bus1.wr_be      = wr_be;
    assign bus1.write_addr = write_addr;
    assign bus1.write_data = write_data;
    assign bus1.rd_en      = rd_en;
    assign bus1.read_addr  = read_addr;

    dual_port_bram_rc #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT), .READ_LATENCY(1), .BYPASS(1'b0)
    ) dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    dual_port_bram_rc #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT), .READ_LATENCY(2), .BYPASS(1'b1)
    ) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: memory contents, cycles left until ready, and what each read port should show.
    logic [31:0] mem_m [DEPTH];
    int          busy;
    logic        exp_v0, exp_v1, pend_v;
    logic [31:0] exp_d0, exp_d1, pend_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic clr, input logic we, input logic [3:0] be,
                        input logic [AW-1:0] wa, input logic [31:0] wd, input logic re,
                        input logic [AW-1:0] ra);
        logic        acc, rd_ok, wr_ok;
        logic [31:0] old, merged;
        reset      = rst;
        clear_req  = clr;
        wr_en      = we;
        wr_be      = be;
        write_addr = wa;
        write_data = wd;
        rd_en      = re;
        read_addr  = ra;

        acc    = !rst && (busy == 0);
        rd_ok  = acc && re;
        wr_ok  = acc && we;
        old    = mem_m[ra];
        merged = old;
        for (int i = 0; i < 4; i++) begin
            if (wr_ok && be[i]) begin
                if (wa == ra) merged[8*i +: 8] = wd[8*i +: 8];
                mem_m[wa][8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (rst || clr) begin
            busy = DEPTH;
            for (int a = 0; a < DEPTH; a++) mem_m[a] = INIT;
        end else if (busy > 0) begin
            busy--;
        end

        if (rst) begin
            exp_v0 = 1'b0; exp_d0 = '0;
            exp_v1 = 1'b0; exp_d1 = '0;
            pend_v = 1'b0; pend_d = '0;
        end else begin
            exp_v0 = rd_ok;
            if (rd_ok) exp_d0 = old;
            exp_v1 = pend_v;
            if (pend_v) exp_d1 = pend_d;
            pend_v = rd_ok;
            if (rd_ok) pend_d = merged;
        end

        @(posedge clk);
        #1;
        check("ready_l1", bus0.ready, busy == 0);
        check("valid_l1", bus0.rd_valid, exp_v0);
        check("data_l1", bus0.read_data, exp_d0);
        check("ready_l2", bus1.ready, busy == 0);
        check("valid_l2", bus1.rd_valid, exp_v1);
        check("data_l2", bus1.read_data, exp_d1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b0, 1'b1, be, a, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1, a);
    endtask

    // Idles until ready rises; start is the number of low cycles already seen.
    task automatic run_until_ready(input int start, input int exp, input string tag);
        int lows  = start;
        int guard = 0;
        while (bus0.ready !== 1'b1 && guard < 100) begin
            idle();
            if (bus0.ready !== 1'b1) lows++;
            guard++;
        end
        check(tag, lows, exp);
    endtask

    initial begin
        busy   = 0;
        exp_v0 = 1'b0; exp_d0 = '0;
        exp_v1 = 1'b0; exp_d1 = '0;
        pend_v = 1'b0; pend_d = '0;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = INIT;

        // Power-up clear, then every entry reads the fill value.
        step(1'b1, 1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        run_until_ready(1, DEPTH, "reset_clear_len");
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));
        idle();

        // Byte-enable read-modify-write.
        wr(4'd3, 32'h11223344, 4'b1111);
        wr(4'd3, 32'hAABBCCDD, 4'b0101);
        rd(4'd3);
        check("rmw_l1", bus0.read_data, 32'h11BB33DD);
        idle();
        check("rmw_l2", bus1.read_data, 32'h11BB33DD);

        // Same-address write and read after a fresh clear: old word vs bypassed merge.
        step(1'b0, 1'b1, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        run_until_ready(1, DEPTH, "clear_req_len");
        step(1'b0, 1'b0, 1'b1, 4'b0001, 4'd5, 32'h000000FF, 1'b1, 4'd5);
        check("nobypass_l1", bus0.read_data, 32'hDEADBEEF);
        idle();
        check("bypass_l2", bus1.read_data, 32'hDEADBEFF);

        // Writes issued during a clear are dropped.
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'(a), 4'hF);
        step(1'b0, 1'b1, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        for (int k = 0; k < 3; k++) wr(4'd2, 32'h55, 4'hF);
        run_until_ready(4, DEPTH, "clear_with_wr_len");
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));
        rd(4'd2);
        check("dropped_wr", bus0.read_data, INIT);

        // clear_req at clear cycle 8 restarts the sweep.
        step(1'b0, 1'b1, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        for (int k = 0; k < 7; k++) idle();
        step(1'b0, 1'b1, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        run_until_ready(9, 24, "restart_clr_len");

        // Read issued with clear_req still completes; reset mid-clear restarts it.
        wr(4'd7, 32'hCAFEF00D, 4'hF);
        step(1'b0, 1'b1, 1'b0, 4'h0, '0, '0, 1'b1, 4'd7);
        check("inflight_l1", bus0.read_data, 32'hCAFEF00D);
        for (int k = 0; k < 7; k++) idle();
        step(1'b1, 1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        run_until_ready(9, 24, "restart_rst_len");

        // Reset flushes a read still in the 2-stage pipe.
        rd(4'd4);
        step(1'b1, 1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        check("flush_v_l2", bus1.rd_valid, 1'b0);
        run_until_ready(1, DEPTH, "reset2_len");

        // Back-to-back reads through the latency-2 instance.
        wr(4'd1, 32'h0101A1A1, 4'hF);
        wr(4'd2, 32'h0202B2B2, 4'hF);
        wr(4'd3, 32'h0303C3C3, 4'hF);
        rd(4'd1);
        check("b2b_v_e1", bus1.rd_valid, 1'b0);
        rd(4'd2);
        check("b2b_d_e2", bus1.read_data, 32'h0101A1A1);
        rd(4'd3);
        check("b2b_d_e3", bus1.read_data, 32'h0202B2B2);
        idle();
        check("b2b_d_e4", bus1.read_data, 32'h0303C3C3);
        idle();

        // Random traffic; the small address space makes same-address collisions common.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
                 1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom), $urandom,
                 1'($urandom_range(0, 1)), AW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dual_port_bram_rc.md
Name: dual_port_bram_rc

Overview:
- Simple dual-port block RAM with hardware clear: one write port, one read port.
- Generalises the reset-clear BRAM with the following:
  - a parameterised fill value;
  - a runtime clear request, in addition to reset;
  - per-byte write enables;
  - a selectable read latency of 1 or 2 cycles;
  - optional same-address write-to-read bypass;
  - a read-valid pipeline.
- Used as a table or state memory in datapath blocks that must re-initialise without a full system reset.

Parameters:
- ADDR_WIDTH, 8: address bits; MEM_DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- INIT_VALUE, '0: word written to every entry during a clear (DATA_WIDTH bits).
- READ_LATENCY, 1: 1 = RAM output direct; 2 = extra output register.
- BYPASS, 0: 1 = a read of an address being written in the same cycle returns the merged new data.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; starts a clear.
- clear_req  in  1  single-cycle pulse; starts a clear at runtime.
- ready  out  1  high when no clear is in progress.
- wr_en  in  1  write strobe.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- write_addr  in  ADDR_WIDTH  write address.
- write_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read strobe.
- read_addr  in  ADDR_WIDTH  read address.
- read_data  out  DATA_WIDTH  read result.
- rd_valid  out  1  read_data holds the result of an accepted read.

Behaviour:
- Two states, CLEAR and READY. Clear counter is ADDR_WIDTH+1 bits.
- Reset:
  - Next state is CLEAR, counter = 0.
  - rd_valid = 0 and the whole valid pipeline is flushed.
  - ready = 0.
  - read_data = 0 (all output registers cleared).
- CLEAR state:
  - Each cycle writes INIT_VALUE, all bytes, to address counter[ADDR_WIDTH-1:0], then increments the counter.
  - When the counter reaches MEM_DEPTH, go to READY and ready goes to 1.
  - A clear therefore takes exactly MEM_DEPTH cycles after the reset/clear_req cycle.
  - Ports are ignored:
    - User wr_en is ignored; the write is dropped, not queued.
    - rd_en is ignored; rd_valid stays 0.
- READY state:
  - clear_req = 1 → next cycle is CLEAR with counter = 0, ready = 0.
  - A write or read presented in the same cycle as clear_req is still performed.
- clear_req or reset during CLEAR restarts the counter at 0 (full re-clear). Reset has priority over clear_req.
- Write (READY, wr_en = 1):
  - Only bytes with wr_be[i] = 1 are updated.
  - wr_be = 0 with wr_en = 1 is a no-op.
- Read (READY, rd_en = 1):
  - read_addr is sampled at edge t.
  - Data and rd_valid = 1 appear after the edge at t+READ_LATENCY-1 (the first edge for latency 1).
  - rd_valid = 0 in cycles with no accepted read.
  - read_data holds its last value when rd_en = 0; it is not required to be zero.
- Same-address read/write in the same cycle:
  - BYPASS = 0: returns the old contents.
  - BYPASS = 1: returns the old word with the enabled bytes replaced by write_data.
  - Different addresses do not interact.
- Write at cycle t, read of the same address at t+1 or later: always returns the new data.
- ready is a registered output; it stays 0 for exactly MEM_DEPTH cycles after a clear trigger.
- Pipeline flush: reads in flight when clear_req is accepted still complete with their valid pulse. Reset flushes them.
- Memory inferred as BRAM: no reset on the storage array; clearing is done only by the clear sequence.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=32, INIT_VALUE=32'hDEADBEEF unless stated):
- Reset high 1 cycle, then low:
  - ready = 0 for exactly 16 cycles, then 1.
  - Reading addresses 0..15 returns 32'hDEADBEEF with rd_valid one cycle after each rd_en.
- Write addr 3 = 32'h11223344 with wr_be = 4'b1111, then addr 3 data 32'hAABBCCDD with wr_be = 4'b0101 → read addr 3 returns 32'h11BB33DD.
- Same-cycle write addr 5 = 32'h0000_00FF (wr_be = 4'b0001) and read addr 5, after a clear:
  - BYPASS = 0 returns 32'hDEADBEEF.
  - BYPASS = 1 returns 32'hDEADBEFF.
- Fill addr 0..15 with the address value, pulse clear_req, then assert wr_en to addr 2 = 32'h55 during CLEAR:
  - ready low for 16 cycles.
  - All entries read 32'hDEADBEEF, including addr 2 (write dropped).
- Pulse clear_req at clear cycle 8 → ready stays low 16 more cycles (24 total).
  - Same check with reset asserted mid-clear: identical restart, and rd_valid forced 0.
- READ_LATENCY = 2, back-to-back reads of addr 1, 2, 3:
  - rd_valid high on the 2nd, 3rd and 4th edges after the first rd_en.
  - Data is in order and matches the written values.
